// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Package  : viterbi_pkg
// Purpose  : shared FSM encoding and code-trellis helpers for the Viterbi decoder
// Revision : 1.0
// ============================================================================
package viterbi_pkg;

  localparam int c_MAXR = 16;
  localparam int c_MAXG = 64;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACS    = 3'd1,
    S_FIND   = 3'd2,
    S_TRACE  = 3'd3,
    S_OUTPUT = 3'd4
  } state_t;

  function automatic int num_states(input int k);
    return 1 << (k - 1);
  endfunction

  function automatic logic parity(input logic [c_MAXG-1:0] v);
    return ^v;
  endfunction

  // Encoder output for input u leaving state s; bit r-1 carries g0.
  function automatic logic [c_MAXR-1:0] expected_sym(input logic [c_MAXG-1:0] gens,
                                                     input int r, input int k,
                                                     input logic u, input int s);
    logic [c_MAXG-1:0] mask;
    logic [c_MAXG-1:0] reg_v;
    logic [c_MAXG-1:0] g;
    logic [c_MAXR-1:0] e;
    e     = '0;
    mask  = (c_MAXG'(1) << k) - c_MAXG'(1);
    reg_v = ((c_MAXG'(u) << (k - 1)) | c_MAXG'(s)) & mask;
    for (int j = 0; j < r; j++) begin
      g = (gens >> ((r - 1 - j) * k)) & mask;
      e[r-1-j] = parity(g & reg_v);
    end
    return e;
  endfunction

  function automatic int hamming(input logic [c_MAXR-1:0] a, input logic [c_MAXR-1:0] b);
    logic [c_MAXR-1:0] x;
    int d;
    x = a ^ b;
    d = 0;
    for (int i = 0; i < c_MAXR; i++) begin
      if (x[i]) d++;
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/viterbi_acs_unit.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_acs_unit
// Purpose  : combinational add-compare-select across every trellis state
// Revision : 1.0
// ============================================================================
module viterbi_acs_unit
  import viterbi_pkg::*;
#(
  parameter int             R    = 2,
  parameter int             K    = 3,
  parameter logic [R*K-1:0] GENS = 6'b111_101,
  parameter int             MW   = 8
) (
  input  logic [(1<<(K-1))*MW-1:0] i_pm,
  input  logic [R-1:0]             i_sym,
  output logic [(1<<(K-1))*MW-1:0] o_pm,
  output logic [(1<<(K-1))-1:0]    o_dec
);

  localparam int c_NS = num_states(K);
  localparam int c_CW = MW + 1;

  for (genvar s = 0; s < c_NS; s++) begin : g_state
    localparam int             c_P0 = (s << 1) % c_NS;
    localparam int             c_P1 = c_P0 + 1;
    localparam logic           c_U  = ((s >> (K - 2)) & 1) != 0;
    localparam logic [R-1:0]   c_E0 = R'(expected_sym(c_MAXG'(GENS), R, K, c_U, c_P0));
    localparam logic [R-1:0]   c_E1 = R'(expected_sym(c_MAXG'(GENS), R, K, c_U, c_P1));

    logic [c_CW-1:0] w_sum0, w_sum1;
    logic [MW-1:0]   w_c0, w_c1;

    assign w_sum0 = {1'b0, i_pm[c_P0*MW +: MW]} + c_CW'(hamming(c_MAXR'(i_sym), c_MAXR'(c_E0)));
    assign w_sum1 = {1'b0, i_pm[c_P1*MW +: MW]} + c_CW'(hamming(c_MAXR'(i_sym), c_MAXR'(c_E1)));
    // Saturate rather than wrap so unreachable states never look cheap.
    assign w_c0 = w_sum0[MW] ? {MW{1'b1}} : w_sum0[MW-1:0];
    assign w_c1 = w_sum1[MW] ? {MW{1'b1}} : w_sum1[MW-1:0];

    assign o_dec[s]           = (w_c1 < w_c0);
    assign o_pm[s*MW +: MW]   = (w_c1 < w_c0) ? w_c1 : w_c0;
  end

endmodule
`default_nettype wire

// File: rtl/viterbi_stream_dec.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_stream_dec
// Purpose  : streaming frame-based hard-decision Viterbi decoder, rate 1/R
// Revision : 1.0
// ============================================================================
module viterbi_stream_dec
  import viterbi_pkg::*;
#(
  parameter int             R      = 2,
  parameter int             K      = 3,
  parameter logic [R*K-1:0] GENS   = 6'b111_101,
  parameter int             MAXLEN = 32,
  parameter int             MW     = 8,
  parameter int             TERM   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sym_valid,
  output logic          sym_ready,
  input  logic [R-1:0]  sym_data,
  input  logic          sym_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_last,
  output logic [MW-1:0] out_metric,
  output logic          busy
);

  localparam int c_NS   = num_states(K);
  localparam int c_SW   = K - 1;
  localparam int c_NW   = $clog2(MAXLEN + 1);
  localparam int c_RW   = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int c_DROP = (TERM != 0) ? K - 1 : 0;
  localparam logic [c_NS*MW-1:0] c_PM_INIT = {{((c_NS-1)*MW){1'b1}}, {MW{1'b0}}};

  state_t                r_state, w_state_nxt;
  logic                  r_alive;
  logic [c_NS*MW-1:0]    r_pm, w_pm_src, w_pm_acs;
  logic [c_NS-1:0]       w_dec;
  logic [c_NS-1:0]       r_ram [MAXLEN];
  logic [MAXLEN-1:0]     r_buf;
  logic [c_NW-1:0]       r_n, w_n_inc;
  logic [c_RW-1:0]       r_row, r_out_idx, w_wr_row, w_last_idx;
  logic [c_SW-1:0]       r_scan, r_best_s, r_tb, w_best_s, w_tb_nxt;
  logic [MW-1:0]         r_best_pm, r_metric, w_scan_pm, w_best_pm;
  logic [c_NS-1:0]       w_tb_row;
  logic                  w_accept, w_take;

  // A fresh frame always starts from the reset metrics, not the previous frame's.
  assign w_pm_src = (r_state == S_IDLE) ? c_PM_INIT : r_pm;

  viterbi_acs_unit #(
    .R    (R),
    .K    (K),
    .GENS (GENS),
    .MW   (MW)
  ) u_acs (
    .i_pm  (w_pm_src),
    .i_sym (sym_data),
    .o_pm  (w_pm_acs),
    .o_dec (w_dec)
  );

  assign sym_ready  = r_alive && ((r_state == S_IDLE) || (r_state == S_ACS));
  assign w_accept   = sym_valid && sym_ready;
  assign w_n_inc    = r_n + 1'b1;
  assign w_wr_row   = (r_state == S_IDLE) ? '0 : c_RW'(r_n);
  assign w_last_idx = c_RW'(int'(r_n) - c_DROP - 1);

  assign w_scan_pm = r_pm[r_scan*MW +: MW];
  assign w_take    = (r_scan == '0) || (w_scan_pm < r_best_pm);
  assign w_best_pm = w_take ? w_scan_pm : r_best_pm;
  assign w_best_s  = w_take ? r_scan : r_best_s;

  assign w_tb_row = r_ram[r_row];
  assign w_tb_nxt = c_SW'({r_tb, w_tb_row[r_tb]});

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = (sym_last || MAXLEN == 1) ? S_FIND : S_ACS;
      S_ACS:    if (w_accept && (sym_last || w_n_inc == c_NW'(MAXLEN))) w_state_nxt = S_FIND;
      S_FIND:   if (TERM != 0 || r_scan == c_SW'(c_NS - 1)) w_state_nxt = S_TRACE;
      S_TRACE:  if (r_row == '0) w_state_nxt = (int'(r_n) > c_DROP) ? S_OUTPUT : S_IDLE;
      S_OUTPUT: if (out_ready && out_last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_alive   <= 1'b0;
      r_pm      <= c_PM_INIT;
      r_n       <= '0;
      r_row     <= '0;
      r_out_idx <= '0;
      r_scan    <= '0;
      r_best_s  <= '0;
      r_best_pm <= '0;
      r_tb      <= '0;
      r_metric  <= '0;
      r_buf     <= '0;
    end else begin
      r_alive <= 1'b1;
      r_state <= w_state_nxt;
      r_scan  <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pm <= w_pm_acs;
            r_n  <= c_NW'(1);
          end
        end
        S_ACS: begin
          if (w_accept) begin
            r_pm <= w_pm_acs;
            r_n  <= w_n_inc;
          end
        end
        S_FIND: begin
          r_scan    <= r_scan + 1'b1;
          r_best_pm <= w_best_pm;
          r_best_s  <= w_best_s;
          if (w_state_nxt == S_TRACE) begin
            r_metric <= w_best_pm;
            r_tb     <= w_best_s;
            r_row    <= c_RW'(int'(r_n) - 1);
          end
        end
        S_TRACE: begin
          r_buf[r_row] <= r_tb[c_SW-1];
          r_tb         <= w_tb_nxt;
          r_row        <= r_row - 1'b1;
          r_out_idx    <= '0;
        end
        S_OUTPUT: begin
          if (out_ready) r_out_idx <= r_out_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Survivor decisions: one NS-bit row per accepted symbol.
  always_ff @(posedge clk) begin
    if (w_accept) r_ram[w_wr_row] <= w_dec;
  end

  assign out_valid  = (r_state == S_OUTPUT);
  assign out_bit    = out_valid && r_buf[r_out_idx];
  assign out_last   = out_valid && (r_out_idx == w_last_idx);
  assign out_metric = r_metric;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_viterbi_stream_dec.sv
`default_nettype none
// ============================================================================
// Module   : tb_viterbi_stream_dec
// Purpose  : directed scoreboard bench for viterbi_stream_dec (three configs)
// Revision : 1.0
// ============================================================================
module tb_viterbi_stream_dec;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      sym_valid, sr, ov, ordy, ob, ol, bz;
  logic [1:0]      sym_data;
  logic            sym_last;
  logic [2:0][7:0] om;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q [$];

  logic [1:0] f_good [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
  logic [1:0] f_bad  [6] = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11};
  logic [1:0] f_m4   [6] = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b01, 2'b01};

  always #5 clk = ~clk;

  viterbi_stream_dec dut0 (
    .clk(clk), .rst(rst), .sym_valid(sym_valid[0]), .sym_ready(sr[0]),
    .sym_data(sym_data), .sym_last(sym_last), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_bit(ob[0]), .out_last(ol[0]), .out_metric(om[0]), .busy(bz[0])
  );

  viterbi_stream_dec #(.TERM(0)) dut1 (
    .clk(clk), .rst(rst), .sym_valid(sym_valid[1]), .sym_ready(sr[1]),
    .sym_data(sym_data), .sym_last(sym_last), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_bit(ob[1]), .out_last(ol[1]), .out_metric(om[1]), .busy(bz[1])
  );

  viterbi_stream_dec #(.MAXLEN(4)) dut2 (
    .clk(clk), .rst(rst), .sym_valid(sym_valid[2]), .sym_ready(sr[2]),
    .sym_data(sym_data), .sym_last(sym_last), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_bit(ob[2]), .out_last(ol[2]), .out_metric(om[2]), .busy(bz[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge after the symbol is taken.
  task automatic send(input int i, input logic [1:0] d, input logic l);
    int cnt;
    cnt = 0;
    sym_valid[i] = 1'b1;
    sym_data     = d;
    sym_last     = l;
    while (!sr[i] && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("send_wait", 32'(cnt < 50), 1);
    @(negedge clk);
  endtask

  task automatic end_frame(input int i);
    sym_valid[i] = 1'b0;
    sym_last     = 1'b0;
  endtask

  task automatic wait_out(input int i, input int exp_lat, input logic [7:0] exp_metric, input string tag);
    int lat;
    lat = 1;
    while (!ov[i] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_metric"}, om[i], exp_metric);
    check({tag, "_ready_low"}, sr[i], 0);
  endtask

  task automatic drain(input int i, input logic [3:0] pat, input string tag);
    int cyc;
    logic [1:0] held, e;
    logic stalled;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (exp_q.size() > 0 && cyc < 200) begin
      ordy[i] = pat[cyc % 4];
      if (stalled) check({tag, "_hold"}, {ov[i], ol[i], ob[i]}, {1'b1, held});
      if (ov[i] && ordy[i]) begin
        e = exp_q.pop_front();
        check({tag, "_bit"}, {ol[i], ob[i]}, e);
        stalled = 1'b0;
      end else if (ov[i]) begin
        held = {ol[i], ob[i]};
        stalled = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    ordy[i] = 1'b0;
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_no_extra"}, ov[i], 0);
    check({tag, "_idle"}, bz[i], 0);
  endtask

  task automatic push_1011();
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst       = 1'b0;
    sym_valid = '0;
    ordy      = '0;
    sym_data  = '0;
    sym_last  = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", sr[i], 0);
      check("rst_outs", {ov[i], ol[i], ob[i], bz[i]}, 0);
      check("rst_metric", om[i], 0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_rst", sr[0], 1);

    // Clean terminated frame.
    push_1011();
    for (int j = 0; j < 6; j++) send(0, f_good[j], j == 5);
    end_frame(0);
    wait_out(0, 8, 8'd0, "s1");
    drain(0, 4'b1111, "s1");

    // One corrupted symbol, sink stalls with pattern 1,0,0,1.
    push_1011();
    for (int j = 0; j < 6; j++) send(0, f_bad[j], j == 5);
    end_frame(0);
    wait_out(0, 8, 8'd1, "s2");
    drain(0, 4'b1001, "s2");

    // Unterminated frame traced from the best state; FIND spans 4 cycles.
    push_1011();
    for (int j = 0; j < 4; j++) send(1, f_good[j], j == 3);
    end_frame(1);
    wait_out(1, 9, 8'd0, "s3");
    drain(1, 4'b1111, "s3");

    // Length-limited frame: only four symbols may be taken.
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    acc = 0;
    sym_valid[2] = 1'b1;
    sym_last = 1'b0;
    for (int c = 0; c < 12; c++) begin
      sym_data = f_m4[acc];
      if (sr[2]) acc++;
      @(negedge clk);
    end
    check("m4_accepted", acc, 4);
    check("m4_ready_low", sr[2], 0);
    check("m4_valid", ov[2], 1);
    check("m4_metric", om[2], 0);
    sym_valid[2] = 1'b0;
    drain(2, 4'b1111, "m4");

    // Reset mid-frame, then a clean frame.
    for (int j = 0; j < 3; j++) send(0, f_good[j], 1'b0);
    check("mid_busy", bz[0], 1);
    sym_valid[0] = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_ready", sr[0], 0);
    check("mid_rst_outs", {ov[0], ol[0], ob[0], bz[0]}, 0);
    check("mid_rst_metric", om[0], 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    push_1011();
    for (int j = 0; j < 6; j++) send(0, f_good[j], j == 5);
    end_frame(0);
    wait_out(0, 8, 8'd0, "s5");
    drain(0, 4'b1111, "s5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
